// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse, flush and occupancy count.
// Optional macro REG_PIPE_PARITY_EN adds a per-stage parity bit and the out_parity port.
module reg_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef REG_PIPE_PARITY_EN
  ,
  output logic                       out_parity
`endif
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned LAST  = DEPTH - 1;

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic [DEPTH-1:0]            adv_c;
  logic                        accept_c;
  logic                        emit_c;

  assign emit_c   = valid_q[LAST] && out_ready && !flush;
  assign in_ready = (!valid_q[0] || adv_c[0]) && !flush && !rst;
  assign accept_c = in_valid && in_ready;

  // Advance chain: a stage moves when its successor is empty or itself moving.
  always_comb begin
    logic carry;
    carry       = emit_c;
    adv_c       = '0;
    adv_c[LAST] = carry;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      carry    = valid_q[i] && (!valid_q[i+1] || carry);
      adv_c[i] = carry;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    occ_d   = occ_q;
    valid_d[0] = accept_c || (valid_q[0] && !adv_c[0]);
    if (accept_c) begin
      data_d[0] = in_data;
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      valid_d[i] = adv_c[i-1] || (valid_q[i] && !adv_c[i]);
      if (adv_c[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end else begin
      occ_d = occ_q + OCC_W'(accept_c) - OCC_W'(emit_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];
  assign occupancy = occ_q;

`ifdef REG_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;

  // Parity is fixed at acceptance and travels with its word.
  always_comb begin
    par_d = par_q;
    if (accept_c) begin
      par_d[0] = ^in_data;
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (adv_c[i-1]) begin
        par_d[i] = par_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_parity = par_q[LAST];
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Directed self-checking bench for reg_pipe at WIDTH=8, DEPTH=4.
module tb_reg_pipe;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] occupancy;
`ifdef REG_PIPE_PARITY_EN
  logic       out_parity;
`endif

  int checks;
  int failures;

  reg_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef REG_PIPE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: wait for the edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL post_reset_accept_occ got=%0d exp=1", occupancy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL cleanup_flush_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_stream();
    int exp_occ;
    out_ready = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      in_valid = 1'b1;
      in_data  = 8'(n);
      tick();
      exp_occ = (n < 4) ? n : 4;
      checks++; if (out_valid !== (n >= 4)) begin failures++; $display("FAIL stream_out_valid n=%0d got=%0h exp=%0h", n, out_valid, (n >= 4)); end
      checks++; if (occupancy !== 3'(exp_occ)) begin failures++; $display("FAIL stream_occ n=%0d got=%0d exp=%0d", n, occupancy, exp_occ); end
      if (n >= 4) begin
        checks++; if (out_data !== 8'(n - 3)) begin failures++; $display("FAIL stream_out_data n=%0d got=%0h exp=%0h", n, out_data, n - 3); end
      end
    end
    in_valid = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      tick();
      checks++; if (out_data !== 8'(9 + m)) begin failures++; $display("FAIL stream_drain_data m=%0d got=%0h exp=%0h", m, out_data, 9 + m); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained_valid got=%0h exp=0", out_valid); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL stream_drained_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA1 + i);
      tick();
    end
    in_data = 8'h99;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0h exp=0", in_ready); end
    tick(); tick();
    checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL bp_occ got=%0d exp=4", occupancy); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%0h exp=1", out_valid); end
    checks++; if (out_data !== 8'hA1) begin failures++; $display("FAIL bp_out_data_held got=%0h exp=a1", out_data); end
  endtask

  task automatic test_full_pass();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'hA3; exp_seq[1] = 8'hA4; exp_seq[2] = 8'h55; exp_seq[3] = 8'h00;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 8'hA2) begin failures++; $display("FAIL full_next_data got=%0h exp=a2", out_data); end
    checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_data !== exp_seq[k]) begin failures++; $display("FAIL full_drain_data k=%0d got=%0h exp=%0h", k, out_data, exp_seq[k]); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_drained_valid got=%0h exp=0", out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 8'h22; tick();
    in_valid = 1'b0; tick(); tick(); tick();
    checks++; if (occupancy !== 3'd2) begin failures++; $display("FAIL bubble_occ got=%0d exp=2", occupancy); end
    checks++; if (out_data !== 8'h11) begin failures++; $display("FAIL bubble_head got=%0h exp=11", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_in_ready got=%0h exp=1", in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 8'h22 || out_valid !== 1'b1) begin failures++; $display("FAIL bubble_second got=%0h/%0h exp=22/1", out_data, out_valid); end
    checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL bubble_occ_after got=%0d exp=1", occupancy); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_empty got=%0h exp=0", out_valid); end
  endtask

  task automatic test_flush_rst();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h31 + i); tick();
    end
    checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=3", occupancy); end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%0h exp=0", out_valid); end
    tick(); tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin failures++; $display("FAIL flush_word_taken got=%0h/%0d exp=0/0", out_valid, occupancy); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h41 + i); tick();
    end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_in_ready got=%0h exp=0", in_ready); end
    tick();
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_mid_out_data got=%0h exp=0", out_data); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%0h exp=0", out_valid); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL rst_mid_occ got=%0d exp=0", occupancy); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

`ifdef REG_PIPE_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h07; tick();
    in_data = 8'h03; tick();
    in_valid = 1'b0; tick(); tick();
    checks++; if (out_data !== 8'h07 || out_parity !== 1'b1) begin failures++; $display("FAIL parity_first got=%0h/%0h exp=07/1", out_data, out_parity); end
    tick();
    checks++; if (out_data !== 8'h03 || out_parity !== 1'b0) begin failures++; $display("FAIL parity_second got=%0h/%0h exp=03/0", out_data, out_parity); end
    tick();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pass();
    test_bubble();
    test_flush_rst();
`ifdef REG_PIPE_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
